// File: rtl/lector_capa_if.sv
// Bus bundle for the azul FIFO drain: FIFO read side, output word stream and
// counter read port. The drain itself uses the slave modport.
interface lector_capa_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 5
);
  logic              Enable;
  logic              init;
  logic [DATA_W-1:0] data_out_fifo_azul_p0;
  logic [DATA_W-1:0] data_out_fifo_azul_p1;
  logic [DATA_W-1:0] data_out_fifo_azul_p2;
  logic [DATA_W-1:0] data_out_fifo_azul_p3;
  logic [3:0]        fifo_empty;
  logic [3:0]        fifo_almost_full;
  logic              ready_in;
  logic [3:0]        pop_fifo_azules;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        src_out;
  logic              dest_error;
  logic              req;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  salida_contador;
  logic              valid_contador;
  logic              idle;

  modport slave (
    input  Enable, init,
    input  data_out_fifo_azul_p0, data_out_fifo_azul_p1,
    input  data_out_fifo_azul_p2, data_out_fifo_azul_p3,
    input  fifo_empty, fifo_almost_full, ready_in, req, idx,
    output pop_fifo_azules, data_out, valid_out, src_out, dest_error,
    output salida_contador, valid_contador, idle
  );

  modport master (
    output Enable, init,
    output data_out_fifo_azul_p0, data_out_fifo_azul_p1,
    output data_out_fifo_azul_p2, data_out_fifo_azul_p3,
    output fifo_empty, fifo_almost_full, ready_in, req, idx,
    input  pop_fifo_azules, data_out, valid_out, src_out, dest_error,
    input  salida_contador, valid_contador, idle
  );
endinterface

// File: rtl/lector_capa.sv
// Drains four azul FIFOs onto one word stream with fixed priority plus an
// almost-full boost, checks destination fields and keeps per-FIFO word counts.
module lector_capa #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 5
) (
  input logic         clk,
  input logic         reset,
  lector_capa_if.slave bus
);

  localparam logic [1:0] StInit   = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              s1_vld_q;
  logic [1:0]        s1_src_q;
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic [1:0]        src_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q [5];
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_vld_q;

  logic [3:0]        avail, boosted, cand, pop;
  logic [1:0]        pop_idx;
  logic              pop_en, in_flight, flush;
  logic [DATA_W-1:0] s1_word;

  // Boosted (almost-full) FIFOs shadow the plain priority order entirely.
  always_comb begin
    avail   = ~bus.fifo_empty;
    boosted = avail & bus.fifo_almost_full;
    cand    = (|boosted) ? boosted : avail;
    pop_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) pop_idx = 2'(i);
    end
    pop_en = reset && !bus.init && bus.Enable && bus.ready_in &&
             (state_q == StActive) && (|cand);
    pop    = pop_en ? (4'b0001 << pop_idx) : 4'b0000;
  end

  assign in_flight = s1_vld_q | vld_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: begin
        if (!bus.init && bus.Enable) state_d = StIdle;
      end
      StIdle: begin
        if (bus.init)        state_d = StInit;
        else if (|avail)     state_d = StActive;
      end
      StActive: begin
        if (bus.init)                     state_d = StInit;
        else if (!(|avail) && !in_flight) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  assign flush = (state_d == StInit);

  always_comb begin
    s1_word = bus.data_out_fifo_azul_p0;
    unique case (s1_src_q)
      2'd0: s1_word = bus.data_out_fifo_azul_p0;
      2'd1: s1_word = bus.data_out_fifo_azul_p1;
      2'd2: s1_word = bus.data_out_fifo_azul_p2;
      2'd3: s1_word = bus.data_out_fifo_azul_p3;
      default: s1_word = bus.data_out_fifo_azul_p0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StInit;
      s1_vld_q  <= 1'b0;
      s1_src_q  <= 2'd0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      src_q     <= 2'd0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        // Entering or holding INIT drops in-flight words without counting them.
        s1_vld_q <= 1'b0;
        vld_q    <= 1'b0;
        data_q   <= '0;
        src_q    <= 2'd0;
        err_q    <= 1'b0;
        for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      end else begin
        s1_vld_q <= pop_en;
        if (pop_en) s1_src_q <= pop_idx;
        vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          data_q <= s1_word;
          src_q  <= s1_src_q;
          if (s1_word[DATA_W-1 -: 2] != s1_src_q) err_q <= 1'b1;
        end
        if (vld_q) begin
          cnt_q[{1'b0, src_q}] <= cnt_q[{1'b0, src_q}] + 1'b1;
          cnt_q[4]             <= cnt_q[4] + 1'b1;
        end
      end
      // Reads sample the registered counters, so a same-cycle increment is not seen.
      if (bus.req && (bus.idx <= 3'd4)) begin
        rd_data_q <= cnt_q[bus.idx];
        rd_vld_q  <= 1'b1;
      end else if (bus.req) begin
        rd_data_q <= '0;
        rd_vld_q  <= 1'b0;
      end else begin
        rd_vld_q  <= 1'b0;
      end
    end
  end

  assign bus.pop_fifo_azules = pop;
  assign bus.data_out        = data_q;
  assign bus.valid_out       = vld_q;
  assign bus.src_out         = src_q;
  assign bus.dest_error      = err_q;
  assign bus.salida_contador = rd_data_q;
  assign bus.valid_contador  = rd_vld_q;
  assign bus.idle            = (state_q == StIdle);

endmodule

// File: tb/tb_lector_capa.sv
// Directed bench for lector_capa: FIFO model on the input side, scoreboard of
// expected words checked by a monitor thread whenever valid_out is high.
module tb_lector_capa;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lector_capa_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lector_capa #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DATA_W-1:0] mem [4][64];
  int                wr_cnt [4];
  int                rd_cnt [4];
  logic [DATA_W-1:0] dreg [4];

  // FIFO model: empty follows the pop edge, read data is valid the cycle after.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.pop_fifo_azules[k]) begin
        dreg[k]   <= mem[k][rd_cnt[k] % 64];
        rd_cnt[k] <= rd_cnt[k] + 1;
      end
    end
  end

  always_comb begin
    bus.fifo_empty = 4'b0000;
    for (int k = 0; k < 4; k++) bus.fifo_empty[k] = (wr_cnt[k] == rd_cnt[k]);
  end

  assign bus.data_out_fifo_azul_p0 = dreg[0];
  assign bus.data_out_fifo_azul_p1 = dreg[1];
  assign bus.data_out_fifo_azul_p2 = dreg[2];
  assign bus.data_out_fifo_azul_p3 = dreg[3];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int k, input logic [DATA_W-1:0] w);
    mem[k][wr_cnt[k] % 64] = w;
    wr_cnt[k]++;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] w, input int k);
    exp_t e;
    e.data = w;
    e.src  = 2'(k);
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.pop_fifo_azules != 4'b0000)
          check("pop_onehot", $countones(bus.pop_fifo_azules), 1);
        if (bus.valid_out) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_word: got data 0x%0h src %0d, expected no word",
                     bus.data_out, bus.src_out);
          end else begin
            e = sb.pop_front();
            check("sb_data", int'(bus.data_out), int'(e.data));
            check("sb_src", int'(bus.src_out), int'(e.src));
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check(name, sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic read_cnt(input int sel, input int exp, input string name);
    bus.req = 1'b1;
    bus.idx = 3'(sel);
    tick();
    bus.req = 1'b0;
    check({name, "_valid"}, int'(bus.valid_contador), 1);
    check({name, "_value"}, int'(bus.salida_contador), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int run, maxrun, delivered;
    logic [DATA_W-1:0] w;
    bus.Enable           = 1'b1;
    bus.init             = 1'b1;
    bus.ready_in         = 1'b1;
    bus.req              = 1'b0;
    bus.idx              = 3'd0;
    bus.fifo_almost_full = 4'b0000;
    fork
      monitor();
    join_none

    // 1: reset, init, release
    reset = 1'b0;
    tick();
    tick();
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_pop", int'(bus.pop_fifo_azules), 0);
    check("rst_idle", int'(bus.idle), 0);
    check("rst_dest_error", int'(bus.dest_error), 0);
    check("rst_valid_contador", int'(bus.valid_contador), 0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("init_idle", int'(bus.idle), 0);
    bus.init = 1'b0;
    tick();
    check("release_idle", int'(bus.idle), 1);
    check("release_pop", int'(bus.pop_fifo_azules), 0);
    check("release_valid_out", int'(bus.valid_out), 0);
    for (int i = 0; i < 5; i++) read_cnt(i, 0, "cnt_zero");

    // 2: single word from p2
    push_word(2, 12'hA77);
    expect_word(12'hA77, 2);
    tick();
    check("single_pop", int'(bus.pop_fifo_azules), 4'b0100);
    wait_drain("single_drain");
    check("single_dest_error", int'(bus.dest_error), 0);
    check("single_idle", int'(bus.idle), 1);
    read_cnt(2, 1, "single_cnt2");
    read_cnt(4, 1, "single_cnt4");

    // 3: priority with p3 boosted
    bus.fifo_almost_full = 4'b1000;
    push_word(0, 12'h011); push_word(0, 12'h022);
    push_word(1, 12'h433); push_word(1, 12'h444);
    push_word(2, 12'h855); push_word(2, 12'h866);
    push_word(3, 12'hC77); push_word(3, 12'hC88);
    expect_word(12'hC77, 3); expect_word(12'hC88, 3);
    expect_word(12'h011, 0); expect_word(12'h022, 0);
    expect_word(12'h433, 1); expect_word(12'h444, 1);
    expect_word(12'h855, 2); expect_word(12'h866, 2);
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.valid_out) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("prio_consecutive_valid", maxrun, 8);
    wait_drain("prio_drain");
    bus.fifo_almost_full = 4'b0000;

    // 4: backpressure mid-stream
    for (int i = 0; i < 6; i++) begin
      w = 12'h0A1 + 12'(i);
      push_word(0, w);
      expect_word(w, 0);
    end
    push_word(1, 12'h4B1); expect_word(12'h4B1, 1);
    push_word(1, 12'h4B2); expect_word(12'h4B2, 1);
    tick();
    tick();
    tick();
    bus.ready_in = 1'b0;
    delivered = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_no_pop", int'(bus.pop_fifo_azules), 0);
      if (bus.valid_out) delivered++;
      tick();
    end
    check("bp_delivered_le2", int'(delivered <= 2), 1);
    bus.ready_in = 1'b1;
    wait_drain("bp_drain");

    // 5: destination error, sticky until init
    push_word(1, 12'hA2D);
    expect_word(12'hA2D, 1);
    wait_drain("dest_drain");
    check("dest_error_set", int'(bus.dest_error), 1);
    tick();
    tick();
    tick();
    check("dest_error_sticky", int'(bus.dest_error), 1);
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    tick();
    check("dest_error_cleared", int'(bus.dest_error), 0);
    check("post_init_idle", int'(bus.idle), 1);
    read_cnt(4, 0, "post_init_cnt4");

    // 6: counters and wrap
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        w = {2'(k), 10'(i + 16 * k)};
        push_word(k, w);
        expect_word(w, k);
      end
    end
    wait_drain("cnt16_drain");
    for (int k = 0; k < 4; k++) read_cnt(k, 4, "cnt16_per_fifo");
    read_cnt(4, 16, "cnt16_total");
    for (int i = 0; i < 20; i++) begin
      w = {2'b00, 10'(256 + i)};
      push_word(0, w);
      expect_word(w, 0);
    end
    wait_drain("cnt20_drain");
    read_cnt(0, 24, "cnt_p0_24");
    read_cnt(4, 4, "cnt_total_wrap");
    bus.req = 1'b1;
    bus.idx = 3'd6;
    tick();
    bus.req = 1'b0;
    check("idx6_valid", int'(bus.valid_contador), 0);
    check("idx6_value", int'(bus.salida_contador), 0);
    check("final_dest_error", int'(bus.dest_error), 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
